// File: rtl/flow_div_sched.sv
// flow_div_sched: round-robin sharing of one fixed-latency divider with tag-matched result return
module flow_div_sched #(
  parameter int NUM_REQ = 4,
  parameter int DIV_LATENCY = 36,
  parameter int DW = 32,
  parameter int ID_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     cfg_en_mask_in,
  input  logic [NUM_REQ-1:0]     req_vld_in,
  output logic [NUM_REQ-1:0]     req_rdy_out,
  input  logic [NUM_REQ*DW-1:0]  req_dividend_in,
  input  logic [NUM_REQ*DW-1:0]  req_divisor_in,
  input  logic [NUM_REQ*ID_W-1:0] req_id_in,
  output logic                   div_vld_out,
  output logic [DW-1:0]          div_dividend_out,
  output logic [DW-1:0]          div_divisor_out,
  input  logic                   div_vld_in,
  input  logic [2*DW-1:0]        div_dout_in,
  output logic                   res_vld_out,
  output logic [2:0]             res_req_out,
  output logic [ID_W-1:0]        res_id_out,
  output logic [2*DW-1:0]        res_data_out,
  output logic                   res_dz_out,
  output logic                   idle_out,
  output logic                   sync_err_out
);
  localparam int TW = ID_W + 5;
  localparam int GW = $clog2(DIV_LATENCY + 2);
  localparam int CW = $clog2(DIV_LATENCY + 1);
  logic [2:0] ptr, off, gidx, iss_req, t_req;
  logic [3:0] sum;
  logic [2*NUM_REQ-1:0] dbl;
  logic found, fire, iss_dz, t_vld, t_dz, ok;
  logic [ID_W-1:0] iss_id, t_id;
  logic [DIV_LATENCY-1:0][TW-1:0] pipe;
  logic [GW-1:0] guard;
  logic [CW-1:0] cnt;
  always_comb begin
    dbl = {req_vld_in & cfg_en_mask_in, req_vld_in & cfg_en_mask_in} >> ptr;
    found = 1'b0;
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (dbl[k]) begin found = 1'b1; off = 3'(k); end
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign gidx = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
  assign fire = found & ~rst;
  assign req_rdy_out = fire ? NUM_REQ'(1) << gidx : '0;
  assign {t_vld, t_req, t_id, t_dz} = pipe[DIV_LATENCY-1];
  assign ok = t_vld & div_vld_in;
  assign idle_out = (cnt == '0) & ~fire;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      div_vld_out <= 1'b0;
      div_dividend_out <= '0;
      div_divisor_out <= '0;
      iss_req <= '0;
      iss_id <= '0;
      iss_dz <= 1'b0;
      pipe <= '0;
      res_vld_out <= 1'b0;
      res_req_out <= '0;
      res_id_out <= '0;
      res_data_out <= '0;
      res_dz_out <= 1'b0;
      sync_err_out <= 1'b0;
      cnt <= '0;
      guard <= GW'(DIV_LATENCY + 1);
    end else begin
      div_vld_out <= found;
      if (found) begin
        ptr <= (gidx == 3'(NUM_REQ - 1)) ? '0 : gidx + 3'd1;
        div_dividend_out <= req_dividend_in[gidx*DW +: DW];
        div_divisor_out <= req_divisor_in[gidx*DW +: DW];
        iss_req <= gidx;
        iss_id <= req_id_in[gidx*ID_W +: ID_W];
        iss_dz <= req_divisor_in[gidx*DW +: DW] == '0;
      end
      pipe <= {pipe[DIV_LATENCY-2:0], div_vld_out, iss_req, iss_id, iss_dz};
      res_vld_out <= ok;
      res_req_out <= ok ? t_req : '0;
      res_id_out <= ok ? t_id : '0;
      res_dz_out <= ok & t_dz;
      res_data_out <= ok ? (t_dz ? '1 : div_dout_in) : '0;
      sync_err_out <= sync_err_out | (t_vld & ~div_vld_in) | (~t_vld & div_vld_in & (guard == '0));
      guard <= (guard == '0) ? guard : guard - 1'b1;
      cnt <= cnt + CW'(div_vld_out) - CW'(t_vld);
    end
  end
endmodule

// File: tb/tb_flow_div_sched.sv
// tb_flow_div_sched: scoreboard bench for flow_div_sched with a behavioural fixed-latency divider
module tb_flow_div_sched;
  localparam int N = 4;
  localparam int L = 36;
  localparam int DW = 32;
  localparam int IW = 10;
  typedef struct {
    int cyc;
    logic [2:0] req;
    logic [IW-1:0] id;
    logic dz;
    logic [2*DW-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] cfg_en_mask_in = '1;
  logic [N-1:0] req_vld_in = '0;
  logic [N-1:0] req_rdy_out;
  logic [N*DW-1:0] req_dividend_in = '0;
  logic [N*DW-1:0] req_divisor_in = '0;
  logic [N*IW-1:0] req_id_in = '0;
  logic div_vld_out;
  logic [DW-1:0] div_dividend_out, div_divisor_out;
  logic div_vld_in;
  logic [2*DW-1:0] div_dout_in;
  logic res_vld_out;
  logic [2:0] res_req_out;
  logic [IW-1:0] res_id_out;
  logic [2*DW-1:0] res_data_out;
  logic res_dz_out, idle_out, sync_err_out;
  logic inject = 1'b0;
  logic [L-1:0] dv_vld = '0;
  logic [2*DW-1:0] dv_dat [L];
  logic [2*DW-1:0] last_data = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sbq[$];
  exp_t mon_e;
  always #5 clk = ~clk;
  flow_div_sched #(.NUM_REQ(N), .DIV_LATENCY(L), .DW(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .cfg_en_mask_in(cfg_en_mask_in), .req_vld_in(req_vld_in),
    .req_rdy_out(req_rdy_out), .req_dividend_in(req_dividend_in), .req_divisor_in(req_divisor_in),
    .req_id_in(req_id_in), .div_vld_out(div_vld_out), .div_dividend_out(div_dividend_out),
    .div_divisor_out(div_divisor_out), .div_vld_in(div_vld_in), .div_dout_in(div_dout_in),
    .res_vld_out(res_vld_out), .res_req_out(res_req_out), .res_id_out(res_id_out),
    .res_data_out(res_data_out), .res_dz_out(res_dz_out), .idle_out(idle_out),
    .sync_err_out(sync_err_out)
  );
  function automatic logic [2*DW-1:0] div_ref(logic [DW-1:0] a, logic [DW-1:0] b);
    if (b == 0) return '0;
    return {32'(a / b), 32'((64'(a % b) << 32) / 64'(b))};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dv_vld <= {dv_vld[L-2:0], div_vld_out};
    for (int i = L - 1; i > 0; i--) dv_dat[i] <= dv_dat[i-1];
    dv_dat[0] <= div_ref(div_dividend_out, div_divisor_out);
  end
  assign div_vld_in = dv_vld[L-1] | inject;
  assign div_dout_in = dv_dat[L-1];
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (res_vld_out) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got req=%0d id=%0d at cycle %0d, required no result", res_req_out, res_id_out, cyc);
        end else begin
          mon_e = sbq.pop_front();
          last_data = res_data_out;
          if (res_req_out !== mon_e.req || res_id_out !== mon_e.id || res_dz_out !== mon_e.dz || res_data_out !== mon_e.data || cyc !== mon_e.cyc) begin
            errors++;
            $display("FAIL result: got req=%0d id=%0d dz=%0b data=%h cyc=%0d, required req=%0d id=%0d dz=%0b data=%h cyc=%0d",
                     res_req_out, res_id_out, res_dz_out, res_data_out, cyc, mon_e.req, mon_e.id, mon_e.dz, mon_e.data, mon_e.cyc);
          end
        end
      end else if ({res_req_out, res_id_out, res_data_out, res_dz_out} !== '0) begin
        errors++;
        $display("FAIL idle_fields: got req=%0d id=%0d data=%h dz=%0b, required all zero", res_req_out, res_id_out, res_data_out, res_dz_out);
      end
    end
  end
  task automatic set_req(int i, logic [DW-1:0] a, logic [DW-1:0] b, logic [IW-1:0] id);
    req_dividend_in[i*DW +: DW] = a;
    req_divisor_in[i*DW +: DW] = b;
    req_id_in[i*IW +: IW] = id;
  endtask
  task automatic tick(output logic [N-1:0] g);
    exp_t e;
    #1;
    g = req_rdy_out;
    for (int i = 0; i < N; i++) if (g[i]) begin
      e.cyc = cyc + L + 2;
      e.req = 3'(i);
      e.id = req_id_in[i*IW +: IW];
      e.dz = req_divisor_in[i*DW +: DW] == 0;
      e.data = e.dz ? '1 : div_ref(req_dividend_in[i*DW +: DW], req_divisor_in[i*DW +: DW]);
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3 * L) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask
  task automatic test_reset();
    req_vld_in = '1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_rdy_out !== '0) begin errors++; $display("FAIL reset_rdy: got %b, required 0000", req_rdy_out); end
    checks++;
    if ({res_vld_out, div_vld_out, sync_err_out, idle_out} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_outputs: got res_vld/div_vld/sync_err/idle=%b, required 0001", {res_vld_out, div_vld_out, sync_err_out, idle_out});
    end
    req_vld_in = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single();
    logic [N-1:0] g;
    set_req(0, 1000, 10, 5);
    req_vld_in = 4'b0001;
    tick(g);
    req_vld_in = '0;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b, required 0001", g); end
    checks++;
    if (div_vld_out !== 1'b1 || div_dividend_out !== 1000 || div_divisor_out !== 10) begin
      errors++;
      $display("FAIL single_issue: got vld=%0b %0d/%0d, required vld=1 1000/10", div_vld_out, div_dividend_out, div_divisor_out);
    end
    @(negedge clk);
    checks++;
    if (div_vld_out !== 1'b0) begin errors++; $display("FAIL single_issue_gap: got div_vld=%0b, required 0", div_vld_out); end
    drain();
    checks++;
    if (last_data[63:32] !== 100) begin errors++; $display("FAIL single_quotient: got %0d, required 100", last_data[63:32]); end
    checks++;
    if (idle_out !== 1'b1) begin errors++; $display("FAIL single_idle: got %0b, required 1", idle_out); end
  endtask
  task automatic test_rr_all();
    logic [N-1:0] g;
    set_req(3, 77, 7, 900);
    req_vld_in = 4'b1000;
    tick(g);
    checks++;
    if (g !== 4'b1000) begin errors++; $display("FAIL rr_align: got %b, required 1000", g); end
    for (int i = 0; i < N; i++) set_req(i, 32'(1000 + i * 37), 32'(i + 3), 10'(16 * i));
    req_vld_in = '1;
    for (int n = 0; n < 8; n++) begin
      tick(g);
      checks++;
      if (g !== (4'b0001 << (n % N))) begin errors++; $display("FAIL rr_grant: step %0d got %b, required %b", n, g, 4'b0001 << (n % N)); end
      for (int i = 0; i < N; i++) if (g[i]) set_req(i, 32'(5000 + n * 111 + i), 32'(i + n + 1), 10'(16 * i + n + 1));
    end
    req_vld_in = '0;
    drain();
  endtask
  task automatic test_dz();
    logic [N-1:0] g;
    set_req(2, 7, 0, 9);
    req_vld_in = 4'b0100;
    tick(g);
    req_vld_in = '0;
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL dz_grant: got %b, required 0100", g); end
    drain();
    checks++;
    if (last_data !== '1) begin errors++; $display("FAIL dz_data: got %h, required all ones", last_data); end
  endtask
  task automatic test_mask();
    logic [N-1:0] g;
    int em [6] = '{3, 0, 2, 3, 0, 2};
    cfg_en_mask_in = 4'b1101;
    req_vld_in = '1;
    for (int n = 0; n < 6; n++) begin
      tick(g);
      checks++;
      if (g !== (4'b0001 << em[n])) begin errors++; $display("FAIL mask_grant: step %0d got %b, required %b", n, g, 4'b0001 << em[n]); end
      for (int i = 0; i < N; i++) if (g[i]) set_req(i, 32'(300 + n * 13), 32'(n + 2), 10'(200 + n));
    end
    req_vld_in = '0;
    cfg_en_mask_in = '1;
    drain();
  endtask
  task automatic test_back_to_back();
    logic [N-1:0] g;
    set_req(1, 640, 8, 40);
    req_vld_in = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      tick(g);
      checks++;
      if (g !== 4'b0010) begin errors++; $display("FAIL b2b_grant: step %0d got %b, required 0010", n, g); end
      set_req(1, 32'(641 + n * 50), 32'(9 + n), 10'(41 + n));
    end
    req_vld_in = '0;
    drain();
  endtask
  task automatic test_reset_inflight();
    logic [N-1:0] g;
    int orphans = 0;
    req_vld_in = '1;
    for (int n = 0; n < 10; n++) begin
      tick(g);
      checks++;
      if (!$onehot(g)) begin errors++; $display("FAIL inflight_grant: step %0d got %b, required one-hot", n, g); end
    end
    req_vld_in = '0;
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    #1;
    checks++;
    if ({res_vld_out, div_vld_out, sync_err_out, idle_out} !== 4'b0001) begin
      errors++;
      $display("FAIL inflight_reset: got res_vld/div_vld/sync_err/idle=%b, required 0001", {res_vld_out, div_vld_out, sync_err_out, idle_out});
    end
    rst = 1'b0;
    repeat (45) begin
      @(negedge clk);
      #1;
      if (div_vld_in) orphans++;
    end
    checks++;
    if (orphans !== 10) begin errors++; $display("FAIL inflight_orphans: got %0d divider results, required 10", orphans); end
    checks++;
    if (sync_err_out !== 1'b0 || idle_out !== 1'b1) begin
      errors++;
      $display("FAIL inflight_quiet: got sync_err=%0b idle=%0b, required 0 1", sync_err_out, idle_out);
    end
  endtask
  task automatic test_orphan();
    logic [N-1:0] g;
    checks++;
    if (sync_err_out !== 1'b0) begin errors++; $display("FAIL orphan_pre: got sync_err=%0b, required 0", sync_err_out); end
    set_req(0, 500, 4, 33);
    req_vld_in = 4'b0001;
    tick(g);
    req_vld_in = '0;
    checks++;
    if (g !== 4'b0001) begin errors++; $display("FAIL orphan_grant: got %b, required 0001", g); end
    repeat (3) @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (sync_err_out !== 1'b1) begin errors++; $display("FAIL orphan_flag: got sync_err=%0b, required 1", sync_err_out); end
    drain();
    set_req(0, 81, 9, 34);
    req_vld_in = 4'b0001;
    tick(g);
    req_vld_in = '0;
    drain();
    checks++;
    if (last_data[63:32] !== 9) begin errors++; $display("FAIL orphan_after: got quotient %0d, required 9", last_data[63:32]); end
    checks++;
    if (sync_err_out !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got sync_err=%0b, required 1", sync_err_out); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_dz();
    test_mask();
    test_back_to_back();
    test_reset_inflight();
    test_orphan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
